// File: rtl/pc_ctrl_if.sv
// Harness-facing bundle for pc_ctrl: control pulses, decode flags, LUT write port, status outputs.
// Latency: none, this is wiring only.
// Backpressure: none; stall is carried as a plain level from the harness.
`timescale 1ns/1ps
interface pc_ctrl_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
);
    logic              start;
    logic              stall;
    logic              halt_req;
    logic              branch;
    logic              taken;
    logic [LUT_AW-1:0] lut_idx;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   pc;
    logic              running;
    logic              done;
    logic [15:0]       instr_count;

    // Harness side: drives control/decode/LUT writes, observes status.
    modport master (
        output start, stall, halt_req, branch, taken, lut_idx,
               lut_we, lut_waddr, lut_wdata,
        input  pc, running, done, instr_count
    );

    // Controller side.
    modport slave (
        input  start, stall, halt_req, branch, taken, lut_idx,
               lut_we, lut_waddr, lut_wdata,
        output pc, running, done, instr_count
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program counter with branch-target LUT, IDLE/RUN/DONE handshake and saturating retired count.
// Latency: pc/state/count change one cycle after the sampling edge; LUT read is combinational.
// Backpressure: stall freezes pc, count and state in RUN; no ready is returned to the harness.
`timescale 1ns/1ps
module pc_ctrl #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    pc_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nxt;
    logic [15:0]       w_cnt_inc;
    logic [PC_W-1:0]   r_lut [2**LUT_AW];
    logic [PC_W-1:0]   w_target;

    // The branch reads the LUT before this edge's write lands, so a same-index
    // write and taken branch resolve to the old target.
    assign w_target  = r_lut[bus.lut_idx];
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // Next-state, next-pc and next-count selection for the three-state controller.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (bus.halt_req) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.branch && bus.taken) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, pc and count registers; reset aborts a run with no partial update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Branch-target LUT: writable in any state, cleared on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**LUT_AW; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.lut_we) begin
            r_lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.pc          = r_pc;
    assign bus.running     = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.instr_count = r_cnt;
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Sequential program-counter and branch-resolution block for the 8-bit core. It is the consumer of the ALU's `taken` flag, holds the architectural PC, and selects increment or branch-LUT target each cycle. It also runs a start/done handshake with the test harness and counts retired instructions.

Parameters:
PC_W, 10, width of program counter (instruction memory depth 2^PC_W)
LUT_AW, 4, branch-target LUT index width (2^LUT_AW entries, each PC_W bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins (or restarts) program execution at PC 0
stall  input  1  hold PC and count this cycle (multi-cycle memory op in flight)
halt_req  input  1  decoded current instruction is HALT
branch  input  1  decoded current instruction is a conditional branch (beq/pos)
taken  input  1  ALU branch condition for the current instruction
lut_idx  input  LUT_AW  branch-target LUT index from current instruction
lut_we  input  1  LUT write enable
lut_waddr  input  LUT_AW  LUT write index
lut_wdata  input  PC_W  LUT write data (absolute target PC)
pc  output  PC_W  current program counter (instruction fetch address)
running  output  1  high while in RUN
done  output  1  high while in DONE
instr_count  output  16  retired-instruction count for the current run

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, pc=0, running=0, done=0, instr_count=0, all LUT entries=0. Reset asserted mid-run aborts immediately; no partial update.
- States: IDLE, RUN, DONE. running = (state==RUN), done = (state==DONE), both registered decodes of state, no extra latency.
- IDLE: pc held at 0. start=1 -> RUN next cycle, pc=0, instr_count=0.
- RUN, per rising edge, priority order:
  1. stall=1: pc, instr_count, state unchanged; halt_req/branch/taken ignored.
  2. halt_req=1: -> DONE; pc unchanged (points at HALT); instr_count+1.
  3. branch=1 and taken=1: pc <= LUT[lut_idx]; instr_count+1.
  4. otherwise: pc <= pc+1, modulo 2^PC_W (2^PC_W-1 wraps to 0); instr_count+1.
- taken=1 with branch=0 is ignored (plain increment). branch=1 with taken=0 increments.
- start while in RUN is ignored.
- DONE: pc, instr_count frozen; done held high indefinitely. start=1 -> RUN, pc=0, instr_count=0 (same as from IDLE).
- instr_count saturates at 16'hFFFF; no wrap.
- Branch latency: target visible on pc one cycle after the edge sampling branch&taken; no delay slot.
- LUT: synchronous write on rising edge when lut_we=1, any state. Read is combinational from lut_idx. Write and branch to the same index on the same edge: branch uses the pre-write (old) value; new value visible from next cycle.
- All inputs are sampled only on rising clk; no combinational path from inputs to pc/running/done/instr_count.

Test Plan:
- Reset/idle: hold reset low 3 cycles, release, no start for 5 cycles -> pc=0, running=0, done=0, instr_count=0 throughout.
- Straight-line + halt: start pulse, 6 non-branch cycles, halt_req on 7th -> pc 0,1,..,6 then holds 6, done=1, running=0, instr_count=7; start again -> pc=0, count=0, running=1.
- Branch resolution: write LUT[3]=10'h155; in RUN at pc=4 assert branch=1,taken=1,lut_idx=3 -> next pc=0x155; branch=1,taken=0 at 0x155 -> next pc=0x156; branch=0,taken=1 -> plain +1.
- Stall priority: at pc=8 assert stall with halt_req=1 and branch/taken=1 for 3 cycles -> pc stays 8, count unchanged, state RUN; release stall with halt_req=1 -> DONE, pc=8.
- Boundaries: run to pc=0x3FF non-branch -> next pc=0; LUT write LUT[2]=0x020 on same edge as taken branch via idx 2 (old value 0x010) -> pc=0x010, next branch via idx 2 -> 0x020; preload count near 0xFFFF by long run -> saturates at 0xFFFF.
- Async reset mid-run: assert reset between clock edges at pc=0x2A, count=42 -> pc, count, running drop to 0 immediately without waiting for clk; LUT contents read back 0.
